// File: rtl/uart_rx_byte_receiver.sv
// UART receive deframer: 2-flop line synchronizer, mid-bit sampling, one-cycle ready/error pulses.
// Define UART_RX_PARITY_EN for 8E1 framing; otherwise 8N1.
module uart_rx_byte_receiver #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned COUNTER_SIZE = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       is_rx_ready,
    output logic       is_rx_busy,
    output logic       is_rx_error
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] StParity   = 3'd3;
`endif
    localparam logic [2:0] StStop     = 3'd4;
    localparam logic [2:0] StWaitHigh = 3'd5;

    localparam logic [COUNTER_SIZE-1:0] CntLast = COUNTER_SIZE'(CLKS_PER_BIT - 1);
    localparam logic [COUNTER_SIZE-1:0] CntHalf = COUNTER_SIZE'(CLKS_PER_BIT / 2 - 1);

    logic                    rx_meta_q, rx_s_q;
    logic [2:0]              state_q, state_d;
    logic [COUNTER_SIZE-1:0] cnt_q, cnt_d;
    logic [2:0]              idx_q, idx_d;
    logic [7:0]              sh_q, sh_d;
    logic [7:0]              rx_data_q, rx_data_d;
    logic                    ready_q, ready_d;
    logic                    error_q, error_d;
    logic                    stop_good;
    logic                    sample;

`ifdef UART_RX_PARITY_EN
    logic par_err_q, par_err_d;
    assign stop_good = rx_s_q && !par_err_q;
`else
    assign stop_good = rx_s_q;
`endif

    assign sample = (cnt_q == CntLast);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        rx_data_d = rx_data_q;
        ready_d   = 1'b0;
        error_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s_q ? StIdle : StData;
`ifdef UART_RX_PARITY_EN
                    par_err_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (sample) begin
                    cnt_d       = '0;
                    sh_d[idx_q] = rx_s_q;
                    idx_d       = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (sample) begin
                    cnt_d     = '0;
                    // Even parity: received bit must equal XOR of the data bits.
                    par_err_d = rx_s_q ^ (^sh_q);
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (sample) begin
                    cnt_d = '0;
                    if (stop_good) begin
                        rx_data_d = sh_q;
                        ready_d   = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        error_d = 1'b1;
                        // A low line here is a break; hold off until it releases.
                        state_d = rx_s_q ? StIdle : StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitHigh: begin
                cnt_d = '0;
                if (rx_s_q) state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            sh_q      <= 8'h00;
            rx_data_q <= 8'h00;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            rx_data_q <= rx_data_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`endif

    assign rx_data     = rx_data_q;
    assign is_rx_ready = ready_q;
    assign is_rx_error = error_q;
    assign is_rx_busy  = (state_q != StIdle);

endmodule
